// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - shared types, attribute bit positions and fault helper for the PMA checker
package pma_pkg;

  // Widest physical address the rule table can hold; narrower instances zero-extend.
  localparam int unsigned PmaMaxAddrW = 64;

  // Bit positions inside the 5-bit attribute vector {NI, C, X, W, R}.
  localparam int unsigned PMA_ATTR_R  = 0;
  localparam int unsigned PMA_ATTR_W  = 1;
  localparam int unsigned PMA_ATTR_X  = 2;
  localparam int unsigned PMA_ATTR_C  = 3;
  localparam int unsigned PMA_ATTR_NI = 4;

  typedef logic [PmaMaxAddrW-1:0] pma_addr_t;

  typedef struct packed {
    logic ni;
    logic c;
    logic x;
    logic w;
    logic r;
  } pma_attr_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    STORE = 2'd1,
    FETCH = 2'd2
  } pma_access_e;

  typedef struct packed {
    pma_addr_t base;
    pma_addr_t len;
    pma_attr_t attr;
    logic      lock;
  } pma_rule_t;

  // Permission check; the reserved access type 3 is checked like a load.
  function automatic logic pma_fault(input pma_attr_t attr, input logic [1:0] acc);
    logic f;
    case (acc)
      STORE:   f = !attr.w;
      FETCH:   f = !attr.x;
      default: f = !attr.r;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pma_range_match.sv
// rtl/pma_range_match.sv - single-rule combinational address range matcher
// Ports:
//   rule_i  - rule entry (only base and len are used here)
//   addr_i  - lookup address
//   match_o - 1 when addr_i lies in [base, base+len) and len != 0
module pma_range_match
  import pma_pkg::*;
#(
  parameter int unsigned AddrWidth = 64
) (
  input  pma_rule_t            rule_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 match_o
);

  logic [AddrWidth-1:0] base;
  logic [AddrWidth-1:0] len;
  logic [AddrWidth:0]   limit;
  logic                 unused_rule_bits;

  assign base  = rule_i.base[AddrWidth-1:0];
  assign len   = rule_i.len[AddrWidth-1:0];

  // One extra bit so a region reaching past the top of the address space
  // still covers everything up to the all-ones address instead of wrapping.
  assign limit = {1'b0, base} + {1'b0, len};

  assign match_o = (len != '0) && (addr_i >= base) && ({1'b0, addr_i} < limit);

  assign unused_rule_bits = ^{rule_i.attr, rule_i.lock};

endmodule

// File: rtl/pma_rule_checker.sv
// rtl/pma_rule_checker.sv - programmable PMA rule table with a 2-stage elastic lookup pipeline
// Ports:
//   clk_i, rst_i                      - clock, synchronous active-high reset
//   cfg_we_i/idx/base/len/attr/lock   - rule write port
//   cfg_err_o                         - one-cycle pulse after a rejected write
//   req_valid_i/req_ready_o           - lookup request handshake
//   req_addr_i, req_type_i            - lookup address and access type
//   resp_valid_o/resp_ready_i         - lookup response handshake
//   resp_hit_o/rule_o/attr_o/fault_o  - lookup result
module pma_rule_checker
  import pma_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned NrRules     = 16,
  parameter logic [4:0]  DefaultAttr = 5'b00011,
  parameter int unsigned RuleIdxW    = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [RuleIdxW-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [4:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [1:0]           req_type_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [RuleIdxW-1:0]  resp_rule_o,
  output logic [4:0]           resp_attr_o,
  output logic                 resp_fault_o
);

  // ---------------- rule table ----------------
  pma_rule_t   rules_q [NrRules];
  logic        cfg_err_q;
  logic [31:0] cfg_idx_ext;
  logic        idx_ok;
  logic        tgt_locked;
  logic        cfg_reject;

  assign cfg_idx_ext = 32'(cfg_idx_i);

  always_comb begin
    idx_ok     = (cfg_idx_ext < NrRules);
    tgt_locked = 1'b0;
    for (int unsigned k = 0; k < NrRules; k++) begin
      if (cfg_idx_ext == k) tgt_locked = rules_q[k].lock;
    end
  end

  assign cfg_reject = !idx_ok || tgt_locked;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NrRules; k++) rules_q[k] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we_i && cfg_reject;
      if (cfg_we_i && !cfg_reject) begin
        for (int unsigned k = 0; k < NrRules; k++) begin
          if (cfg_idx_ext == k) begin
            rules_q[k].base <= pma_addr_t'(cfg_base_i);
            rules_q[k].len  <= pma_addr_t'(cfg_len_i);
            rules_q[k].attr <= pma_attr_t'(cfg_attr_i);
            rules_q[k].lock <= cfg_lock_i;
          end
        end
      end
    end
  end

  assign cfg_err_o = cfg_err_q;

  // ---------------- match against the live table ----------------
  logic [NrRules-1:0] match_now;

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    pma_range_match #(.AddrWidth(AddrWidth)) u_match (
      .rule_i  (rules_q[g]),
      .addr_i  (req_addr_i),
      .match_o (match_now[g])
    );
  end

  // ---------------- pipeline control ----------------
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, accept;

  assign s2_adv      = !s2_valid || resp_ready_i;
  assign s1_adv      = s2_adv || !s1_valid;
  assign req_ready_o = !rst_i && s1_adv;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= accept;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // ---------------- stage S1 ----------------
  // Attributes are snapshotted alongside the match vector so a rule write
  // landing while the lookup sits in S1 cannot leak into its result.
  logic [AddrWidth-1:0] s1_addr;
  logic [1:0]           s1_type;
  logic [NrRules-1:0]   s1_match;
  pma_attr_t            s1_attr [NrRules];

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_addr  <= req_addr_i;
      s1_type  <= req_type_i;
      s1_match <= match_now;
      for (int unsigned k = 0; k < NrRules; k++) s1_attr[k] <= rules_q[k].attr;
    end
  end

  // Lowest matching index wins: scan downward so the last assignment sticks.
  logic                enc_hit;
  logic [RuleIdxW-1:0] enc_idx;
  pma_attr_t           enc_attr;
  logic                enc_fault;
  logic                unused_s1_addr;

  always_comb begin
    enc_hit  = 1'b0;
    enc_idx  = '0;
    enc_attr = pma_attr_t'(DefaultAttr);
    for (int k = NrRules - 1; k >= 0; k--) begin
      if (s1_match[k]) begin
        enc_hit  = 1'b1;
        enc_idx  = k[RuleIdxW-1:0];
        enc_attr = s1_attr[k];
      end
    end
    enc_fault = pma_fault(enc_attr, s1_type);
  end

  assign unused_s1_addr = ^s1_addr;

  // ---------------- stage S2 ----------------
  logic                s2_hit;
  logic [RuleIdxW-1:0] s2_rule;
  pma_attr_t           s2_attr;
  logic                s2_fault;

  always_ff @(posedge clk_i) begin
    if (s2_adv && s1_valid) begin
      s2_hit   <= enc_hit;
      s2_rule  <= enc_idx;
      s2_attr  <= enc_attr;
      s2_fault <= enc_fault;
    end
  end

  // Reset is synchronous, so the valid is also masked while rst_i is high.
  assign resp_valid_o = s2_valid && !rst_i;
  assign resp_hit_o   = s2_hit;
  assign resp_rule_o  = s2_rule;
  assign resp_attr_o  = s2_attr;
  assign resp_fault_o = s2_fault;

endmodule

// File: tb/tb_pma_rule_checker.sv
// tb/tb_pma_rule_checker.sv - scoreboard bench for pma_rule_checker
module tb_pma_rule_checker;

  typedef struct packed {
    logic       hit;
    logic [3:0] rule;
    logic [4:0] attr;
    logic       fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [63:0] cfg_base, cfg_len;
  logic [4:0]  cfg_attr;
  logic        cfg_lock;
  logic        cfg_err;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_type;
  logic        resp_valid, resp_ready;
  logic        resp_hit;
  logic [3:0]  resp_rule;
  logic [4:0]  resp_attr;
  logic        resp_fault;

  int checks = 0;
  int errors = 0;
  resp_t exp_q[$];

  pma_rule_checker #(.AddrWidth(64), .NrRules(12), .DefaultAttr(5'b00011)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
    .cfg_attr_i(cfg_attr), .cfg_lock_i(cfg_lock), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_type_i(req_type),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
    .resp_rule_o(resp_rule), .resp_attr_o(resp_attr), .resp_fault_o(resp_fault)
  );

  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  resp_t got, exp_r, prev;
  logic  stall_prev = 1'b0;

  always @(negedge clk) begin
    got = {resp_hit, resp_rule, resp_attr, resp_fault};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!resp_valid || got !== prev) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%h, need valid=1 data=%h", resp_valid, got, prev);
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got data=%h, none expected", got);
        end else begin
          exp_r = exp_q.pop_front();
          if (got !== exp_r) begin
            errors++;
            $display("FAIL resp: got hit=%0b rule=%0d attr=%h fault=%0b, need hit=%0b rule=%0d attr=%h fault=%0b",
                     got.hit, got.rule, got.attr, got.fault, exp_r.hit, exp_r.rule, exp_r.attr, exp_r.fault);
          end
        end
      end
      stall_prev = resp_valid && !resp_ready;
      prev = got;
    end
  end

  // ---------------- helpers ----------------
  function automatic resp_t mk(input logic h, input logic [3:0] r, input logic [4:0] a, input logic f);
    return {h, r, a, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [63:0] base, input logic [63:0] len,
                           input logic [4:0] attr, input logic lock, input logic exp_err);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_len = len; cfg_attr = attr; cfg_lock = lock;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, exp_err});
    if (exp_err) begin
      tick();
      @(negedge clk);
      chk("cfg_err_pulse", {63'd0, cfg_err}, 64'd0);
    end
    tick();
  endtask

  task automatic send(input logic [63:0] a, input logic [1:0] t, input resp_t e);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    req_valid = 1'b1; req_addr = a; req_type = t;
    exp_q.push_back(e);
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      void'(exp_q.pop_back());
      $display("FAIL accept_timeout: addr=%h not accepted in %0d cycles", a, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, need 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0; cfg_attr = '0; cfg_lock = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_type = 2'd0; resp_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    tick();

    // basic hit/miss and latency; attr R|W|C = 0x0B
    cfg_write(4'd0, 64'h8000_0000, 64'h1000, 5'h0B, 1'b0, 1'b0);
    send(64'h8000_0FFF, 2'd0, mk(1'b1, 4'd0, 5'h0B, 1'b0));
    @(negedge clk);
    chk("latency_s1", {63'd0, resp_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("latency_s2", {63'd0, resp_valid}, 64'd1);
    tick();
    send(64'h8000_1000, 2'd0, mk(1'b0, 4'd0, 5'h03, 1'b0));
    send(64'h8000_1000, 2'd2, mk(1'b0, 4'd0, 5'h03, 1'b1));
    drain();

    // overlap priority; rule 0 disabled with len=0 (must never hit)
    cfg_write(4'd0, 64'h8000_0000, 64'h0, 5'h1F, 1'b0, 1'b0);
    cfg_write(4'd1, 64'h8000_0000, 64'h100, 5'h01, 1'b0, 1'b0);
    cfg_write(4'd3, 64'h8000_0000, 64'h1000, 5'h07, 1'b0, 1'b0);
    send(64'h8000_0010, 2'd1, mk(1'b1, 4'd1, 5'h01, 1'b1));
    send(64'h8000_0200, 2'd2, mk(1'b1, 4'd3, 5'h07, 1'b0));
    send(64'h8000_0010, 2'd0, mk(1'b1, 4'd1, 5'h01, 1'b0));
    send(64'h8000_0010, 2'd3, mk(1'b1, 4'd1, 5'h01, 1'b0));
    drain();

    // lock and out-of-range index
    cfg_write(4'd2, 64'h9000_0000, 64'h100, 5'h01, 1'b1, 1'b0);
    cfg_write(4'd2, 64'hA000_0000, 64'h100, 5'h1F, 1'b0, 1'b1);
    send(64'h9000_0010, 2'd0, mk(1'b1, 4'd2, 5'h01, 1'b0));
    send(64'h9000_0010, 2'd1, mk(1'b1, 4'd2, 5'h01, 1'b1));
    send(64'hA000_0010, 2'd0, mk(1'b0, 4'd0, 5'h03, 1'b0));
    cfg_write(4'd13, 64'hD000_0000, 64'h100, 5'h1F, 1'b0, 1'b1);
    cfg_write(4'd12, 64'hD000_0000, 64'h100, 5'h1F, 1'b0, 1'b1);
    cfg_write(4'd11, 64'hC000_0000, 64'h10, 5'h04, 1'b0, 1'b0);
    send(64'hC000_000F, 2'd2, mk(1'b1, 4'd11, 5'h04, 1'b0));
    send(64'hC000_000F, 2'd0, mk(1'b1, 4'd11, 5'h04, 1'b1));
    send(64'hD000_0000, 2'd0, mk(1'b0, 4'd0, 5'h03, 1'b0));
    drain();

    // backpressure: two accepted, third blocked, then in-order release
    resp_ready = 1'b0;
    send(64'h8000_0010, 2'd0, mk(1'b1, 4'd1, 5'h01, 1'b0));
    send(64'h8000_0800, 2'd1, mk(1'b1, 4'd3, 5'h07, 1'b0));
    req_valid = 1'b1; req_addr = 64'h9000_0000; req_type = 2'd2;
    @(negedge clk);
    chk("bp_ready_low", {63'd0, req_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("bp_ready_low2", {63'd0, req_ready}, 64'd0);
    chk("bp_head_rule", {60'd0, resp_rule}, 64'd1);
    tick();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    send(64'h9000_0000, 2'd2, mk(1'b1, 4'd2, 5'h01, 1'b1));
    drain();

    // same-cycle write and accept
    cfg_write(4'd4, 64'hB000_0000, 64'h100, 5'h01, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_idx = 4'd4; cfg_base = 64'hB000_0000; cfg_len = 64'h100; cfg_attr = 5'h03; cfg_lock = 1'b0;
    req_valid = 1'b1; req_addr = 64'hB000_0000; req_type = 2'd1;
    exp_q.push_back(mk(1'b1, 4'd4, 5'h01, 1'b1));
    @(negedge clk);
    chk("same_cycle_ready", {63'd0, req_ready}, 64'd1);
    tick();
    cfg_we = 1'b0;
    exp_q.push_back(mk(1'b1, 4'd4, 5'h03, 1'b0));
    @(negedge clk);
    chk("next_cycle_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    drain();

    // top-of-address-space region
    cfg_write(4'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 5'h1F, 1'b0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 2'd0, mk(1'b1, 4'd0, 5'h1F, 1'b0));
    send(64'hFFFF_FFFF_FFFF_F000, 2'd2, mk(1'b1, 4'd0, 5'h1F, 1'b0));
    send(64'hFFFF_FFFF_FFFF_EFFF, 2'd2, mk(1'b0, 4'd0, 5'h03, 1'b1));
    send(64'h0, 2'd0, mk(1'b0, 4'd0, 5'h03, 1'b0));
    drain();

    // reset with two lookups in flight
    resp_ready = 1'b0;
    send(64'h8000_0010, 2'd0, mk(1'b1, 4'd1, 5'h01, 1'b0));
    send(64'h9000_0010, 2'd0, mk(1'b1, 4'd2, 5'h01, 1'b0));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_inflight_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_inflight_ready", {63'd0, req_ready}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", {63'd0, resp_valid}, 64'd0);
    resp_ready = 1'b1;
    repeat (5) tick();
    send(64'h8000_0010, 2'd0, mk(1'b0, 4'd0, 5'h03, 1'b0));
    send(64'h9000_0010, 2'd2, mk(1'b0, 4'd0, 5'h03, 1'b1));
    send(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, mk(1'b0, 4'd0, 5'h03, 1'b0));
    drain();
    cfg_write(4'd2, 64'hA000_0000, 64'h100, 5'h1F, 1'b0, 1'b0);
    send(64'hA000_0010, 2'd2, mk(1'b1, 4'd2, 5'h1F, 1'b0));
    drain();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
